md_issue: RTL

//  EX-stage issue controller for the multiply/divide unit, directly upstream of the HI/LO block.

---
 rtl/md_pkg.sv | 52 +++++
 rtl/md_issue.sv | 126 ++++++++++++
 2 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide issue controller.
//   md_op_e      EX-stage MD instruction class (4-bit code)
//   md_state_e   issue controller state (IDLE / HELD)
//   HILO_*       operation codes sent to the HI/LO block
//   is_*()       class decode helpers
package md_pkg;

    localparam int MD_OP_W = 4;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HELD = 2'b01
    } md_state_e;

    localparam logic [1:0] HILO_MULTU = 2'd0;
    localparam logic [1:0] HILO_MULT  = 2'd1;
    localparam logic [1:0] HILO_DIVU  = 2'd2;
    localparam logic [1:0] HILO_DIV   = 2'd3;

    function automatic logic is_md(input logic [MD_OP_W-1:0] op);
        return (op >= MD_MULT) && (op <= MD_MFLO);
    endfunction

    function automatic logic is_arith(input logic [MD_OP_W-1:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic logic is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mt(input logic [MD_OP_W-1:0] op);
        return (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

    function automatic logic is_mf(input logic [MD_OP_W-1:0] op);
        return (op == MD_MFHI) || (op == MD_MFLO);
    endfunction

endpackage

// File: rtl/md_issue.sv
// md_issue: EX-stage issue controller for the multiply/divide unit.
// Decodes the EX instruction's MD class, sends exactly one start/we pulse
// per instruction, stalls EX on HI/LO hazards, raises rollback for a
// late-flushed HI/LO write, and returns mfhi/mflo data.
//
// State table:
//   state   | meaning
//   IDLE    | no pulse sent yet for the instruction in EX
//   HELD    | pulse already sent; EX is held by an unrelated stall
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-low reset
//   i_ex_valid, i_ex_md_op    EX instruction and its MD class
//   i_ex_rs, i_ex_rt          forwarded operands
//   i_ex_advance, i_flush_ex  EX moves on / EX killed
//   i_flush_late              kill of the instruction issued last cycle
//   i_hilo_busy, i_hilo_rd    HI/LO status and read data
//   o_hilo_a/b/op             operands and op code to HI/LO
//   o_hilo_start/we/rollback  one-cycle pulses to HI/LO
//   o_md_stall                hold EX and upstream
//   o_md_result               mfhi/mflo data
module md_issue
    import md_pkg::*;
#(
    parameter int OP_W          = 4,
    parameter bit DIV_ZERO_SKIP = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_ex_valid,
    input  logic [OP_W-1:0] i_ex_md_op,
    input  logic [31:0]     i_ex_rs,
    input  logic [31:0]     i_ex_rt,
    input  logic            i_ex_advance,
    input  logic            i_flush_ex,
    input  logic            i_flush_late,
    input  logic            i_hilo_busy,
    input  logic [31:0]     i_hilo_rd,
    output logic [31:0]     o_hilo_a,
    output logic [31:0]     o_hilo_b,
    output logic [1:0]      o_hilo_op,
    output logic            o_hilo_start,
    output logic            o_hilo_we,
    output logic            o_hilo_rollback,
    output logic            o_md_stall,
    output logic [31:0]     o_md_result
);

    md_state_e          r_state;
    logic               r_spec;
    md_state_e          w_state_nxt;
    logic [MD_OP_W-1:0] w_op;
    logic               w_dep;
    logic               w_issued;
    logic               w_issue;
    logic               w_div_skip;
    logic               w_start;
    logic               w_we;

    assign w_op = MD_OP_W'(i_ex_md_op);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_spec  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // HI/LO keeps exactly one cycle of shadow state, so the
            // rollback window is the single cycle after a pulse.
            r_spec  <= w_start | w_we;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_dep           = 1'b0;
        w_issued        = 1'b0;
        w_issue         = 1'b0;
        w_div_skip      = 1'b0;
        w_start         = 1'b0;
        w_we            = 1'b0;
        o_md_stall      = 1'b0;
        o_hilo_rollback = 1'b0;
        o_md_result     = 32'd0;

        w_dep      = i_ex_valid & is_md(w_op);
        w_issued   = (r_state == ST_HELD);
        w_div_skip = DIV_ZERO_SKIP & is_div(w_op) & (i_ex_rt == 32'd0);

        // Gating with i_reset keeps every pulse and the stall low while
        // reset is asserted, independent of the registered state.
        o_md_stall = i_reset & w_dep & i_hilo_busy & ~w_issued & ~i_flush_ex;
        w_issue    = i_reset & w_dep & ~i_hilo_busy & ~w_issued & ~i_flush_ex;
        w_start    = w_issue & is_arith(w_op) & ~w_div_skip;
        w_we       = w_issue & is_mt(w_op);

        o_hilo_rollback = i_reset & i_flush_late & r_spec;

        if (w_dep & ~i_hilo_busy & is_mf(w_op))
            o_md_result = i_hilo_rd;

        if (i_flush_ex | i_ex_advance)
            w_state_nxt = ST_IDLE;
        else if (w_start | w_we)
            w_state_nxt = ST_HELD;
    end

    always_comb begin
        o_hilo_op = 2'd0;
        case (w_op)
            MD_MULT:  o_hilo_op = HILO_MULT;
            MD_MULTU: o_hilo_op = HILO_MULTU;
            MD_DIV:   o_hilo_op = HILO_DIV;
            MD_DIVU:  o_hilo_op = HILO_DIVU;
            MD_MTHI:  o_hilo_op = 2'b01;
            MD_MFHI:  o_hilo_op = 2'b01;
            default:  o_hilo_op = 2'b00;
        endcase
    end

    assign o_hilo_a     = i_ex_rs;
    assign o_hilo_b     = i_ex_rt;
    assign o_hilo_start = w_start;
    assign o_hilo_we    = w_we;

endmodule
